tdc_scan_sequencer: RTL
=======================

// Module: tdc_scan_sequencer
// PURPOSE
//  Sequences one TDC phase-scan experiment: steps the dynamic PLL clock phase, fires the
//  carry-chain start pulse, strobes register capture, writes the response RAM, clears registers.
//  Sits between the start button/host and the PLL phase port, the CarryChain enables and RAM_response.
//  Adds repeat-per-step, handshake timeouts, lock-loss detection and abort.
// PARAMETERS
//  N_STEPS     512   phase steps per scan (>=1); step 0 measured at initial phase, no shift
//  N_REPS      1     TDC shots per phase step (>=1)
//  SETTLE_CYC  4     idle cycles after each phase step before the first shot (>=1)
//  TIMEOUT_CYC 1024  max cycles waiting on pll_locked or a phase_done edge
//  ADDR_W      $clog2(N_STEPS*N_REPS)  RAM address width (min 1)
// PORTS
//  clk          in   1       system clock (the phase-shifted-domain controller clock)
//  rst          in   1       synchronous, active-high reset
//  start        in   1       1-cycle pulse: begin scan (honoured only in IDLE, DONE, ERROR)
//  abort        in   1       level: stop scan, return to IDLE
//  pll_locked   in   1       PLL lock status
//  phase_done   in   1       PLL phase-step handshake; low while a step is in progress
//  phase_en     out  1       PLL phase-step request
//  tdc_fire     out  1       1-cycle start pulse into carry chain
//  reg_ena      out  1       carry-chain register enable (same cycle as tdc_fire)
//  reg_clr      out  1       carry-chain register clear
//  mem_we       out  1       response RAM write strobe
//  mem_addr     out  ADDR_W  response RAM address = step*N_REPS + rep
//  busy         out  1       high in every state except IDLE, DONE, ERROR
//  done         out  1       scan completed; held until next start/rst/abort
//  err          out  2       01 handshake timeout, 10 lock lost; held until start/rst/abort
// BEHAVIOUR
//  Reset: state IDLE, all outputs 0, step/rep/timeout counters 0.
//  States and transitions (one per clk):
//   IDLE    : start -> LOCK; clears done, err, step, rep, mem_addr.
//   LOCK    : pll_locked -> SETTLE (step 0 needs no shift); timeout -> ERROR(01).
//   PH_REQ  : phase_en=1; -> PH_ACK.
//   PH_ACK  : phase_en=1 until phase_done==0 seen, then phase_en=0 -> PH_WAIT; timeout -> ERROR(01).
//   PH_WAIT : phase_done==1 -> SETTLE; timeout -> ERROR(01).
//   SETTLE  : count SETTLE_CYC cycles -> FIRE.
//   FIRE    : tdc_fire=1, reg_ena=1 for exactly 1 cycle -> CAPT.
//   CAPT    : mem_we=1 with mem_addr valid the same cycle -> CLR.
//   CLR     : reg_clr=1; rep<N_REPS-1 -> rep++, addr++, FIRE;
//             else step<N_STEPS-1 -> rep=0, step++, addr++, PH_REQ; else DONE.
//   DONE    : done=1; start -> LOCK (restart).  ERROR: phase_en=0, err held; start -> LOCK.
//  Timeout counter resets on each entry to LOCK/PH_ACK/PH_WAIT; fires when count==TIMEOUT_CYC.
//  Lock loss: pll_locked==0 in any busy state except LOCK -> ERROR(10) next cycle, strobes 0.
//  Priority per cycle: rst > abort > lock-loss > timeout > normal transition.
//  abort: next cycle IDLE, all strobes 0, done/err cleared; an in-flight PLL step is not waited on.
//  start while busy ignored. mem_addr never wraps; exactly N_STEPS*N_REPS writes per scan,
//  addresses 0..N_STEPS*N_REPS-1 in order. phase_en never high outside PH_REQ/PH_ACK.
//  tdc_fire/reg_ena/mem_we/reg_clr mutually exclusive, each 1 cycle wide.
//  Latency: per shot 3 cycles (FIRE,CAPT,CLR); per step >=SETTLE_CYC+3 + PLL handshake.
// TESTING
//  N_STEPS=4,N_REPS=2, locked=1, PLL model phase_done low 3 cyc -> 8 mem_we at addr 0..7,
//   3 phase_en requests, done=1, busy=0.
//  Count cycles step-0 SETTLE->first mem_we: SETTLE_CYC=4 -> mem_we exactly 5 cycles after SETTLE entry.
//  phase_done stuck high after phase_en -> ERROR after TIMEOUT_CYC, err=01, phase_en=0, no more writes.
//  Drop pll_locked during FIRE of step 2 -> next cycle ERROR, err=10, no mem_we that shot.
//  abort during PH_WAIT -> IDLE next cycle, all outputs 0; then start -> full scan from addr 0.
//  start pulse while busy ignored; start in DONE restarts with done cleared, addr 0.

Source files
------------

// File: rtl/tdc_scan_sequencer.sv
// TDC phase-scan sequencer: steps the PLL phase, fires the carry chain,
// strobes capture, writes the response RAM and clears the chain registers.
module tdc_scan_sequencer #(
  parameter int unsigned N_STEPS     = 512,
  parameter int unsigned N_REPS      = 1,
  parameter int unsigned SETTLE_CYC  = 4,
  parameter int unsigned TIMEOUT_CYC = 1024,
  parameter int unsigned ADDR_W      = ((N_STEPS * N_REPS) > 1) ? $clog2(N_STEPS * N_REPS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              pll_locked,
  input  logic              phase_done,
  output logic              phase_en,
  output logic              tdc_fire,
  output logic              reg_ena,
  output logic              reg_clr,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              busy,
  output logic              done,
  output logic [1:0]        err
);

  localparam int unsigned STEP_W = (N_STEPS > 1) ? $clog2(N_STEPS) : 1;
  localparam int unsigned REP_W  = (N_REPS > 1) ? $clog2(N_REPS) : 1;
  localparam int unsigned SET_W  = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam int unsigned TO_W   = $clog2(TIMEOUT_CYC + 1);

  localparam logic [1:0] ERR_TIMEOUT  = 2'b01;
  localparam logic [1:0] ERR_LOCKLOST = 2'b10;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOCK,
    S_PH_REQ,
    S_PH_ACK,
    S_PH_WAIT,
    S_SETTLE,
    S_FIRE,
    S_CAPT,
    S_CLR,
    S_DONE,
    S_ERROR
  } state_t;

  state_t            state;
  logic [STEP_W-1:0] step;
  logic [REP_W-1:0]  rep;
  logic [SET_W-1:0]  set_cnt;
  logic [TO_W-1:0]   to_cnt;

  logic lock_lost_c;
  logic timeout_c;

  // Lock loss is only meaningful once LOCK has been passed; timeouts only in handshake waits
  assign lock_lost_c = !pll_locked &&
                       (state inside {S_PH_REQ, S_PH_ACK, S_PH_WAIT, S_SETTLE, S_FIRE, S_CAPT, S_CLR});
  assign timeout_c   = (to_cnt == TO_W'(TIMEOUT_CYC)) &&
                       (state inside {S_LOCK, S_PH_ACK, S_PH_WAIT});

  // Sequencer FSM; every output is registered and set on entry to the state that owns it
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      phase_en <= 1'b0;
      tdc_fire <= 1'b0;
      reg_ena  <= 1'b0;
      reg_clr  <= 1'b0;
      mem_we   <= 1'b0;
      mem_addr <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 2'b00;
      step     <= '0;
      rep      <= '0;
      set_cnt  <= '0;
      to_cnt   <= '0;
    end else begin
      tdc_fire <= 1'b0;
      reg_ena  <= 1'b0;
      reg_clr  <= 1'b0;
      mem_we   <= 1'b0;
      if (abort) begin
        state    <= S_IDLE;
        phase_en <= 1'b0;
        mem_addr <= '0;
        busy     <= 1'b0;
        done     <= 1'b0;
        err      <= 2'b00;
        step     <= '0;
        rep      <= '0;
        set_cnt  <= '0;
        to_cnt   <= '0;
      end else if (lock_lost_c) begin
        state    <= S_ERROR;
        phase_en <= 1'b0;
        busy     <= 1'b0;
        err      <= ERR_LOCKLOST;
      end else if (timeout_c) begin
        state    <= S_ERROR;
        phase_en <= 1'b0;
        busy     <= 1'b0;
        err      <= ERR_TIMEOUT;
      end else begin
        case (state)
          S_IDLE, S_DONE, S_ERROR: begin
            if (start) begin
              state    <= S_LOCK;
              busy     <= 1'b1;
              done     <= 1'b0;
              err      <= 2'b00;
              step     <= '0;
              rep      <= '0;
              mem_addr <= '0;
              to_cnt   <= '0;
            end
          end
          S_LOCK: begin
            if (pll_locked) begin
              state   <= S_SETTLE;
              set_cnt <= '0;
            end else begin
              to_cnt <= to_cnt + TO_W'(1);
            end
          end
          S_PH_REQ: begin
            state  <= S_PH_ACK;
            to_cnt <= '0;
          end
          S_PH_ACK: begin
            if (!phase_done) begin
              state    <= S_PH_WAIT;
              phase_en <= 1'b0;
              to_cnt   <= '0;
            end else begin
              to_cnt <= to_cnt + TO_W'(1);
            end
          end
          S_PH_WAIT: begin
            if (phase_done) begin
              state   <= S_SETTLE;
              set_cnt <= '0;
            end else begin
              to_cnt <= to_cnt + TO_W'(1);
            end
          end
          S_SETTLE: begin
            if (set_cnt == SET_W'(SETTLE_CYC - 1)) begin
              state    <= S_FIRE;
              tdc_fire <= 1'b1;
              reg_ena  <= 1'b1;
            end else begin
              set_cnt <= set_cnt + SET_W'(1);
            end
          end
          S_FIRE: begin
            state  <= S_CAPT;
            mem_we <= 1'b1;
          end
          S_CAPT: begin
            state   <= S_CLR;
            reg_clr <= 1'b1;
          end
          S_CLR: begin
            if (rep != REP_W'(N_REPS - 1)) begin
              state    <= S_FIRE;
              rep      <= rep + REP_W'(1);
              mem_addr <= mem_addr + ADDR_W'(1);
              tdc_fire <= 1'b1;
              reg_ena  <= 1'b1;
            end else if (step != STEP_W'(N_STEPS - 1)) begin
              state    <= S_PH_REQ;
              rep      <= '0;
              step     <= step + STEP_W'(1);
              mem_addr <= mem_addr + ADDR_W'(1);
              phase_en <= 1'b1;
            end else begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
          default: begin
            state    <= S_IDLE;
            phase_en <= 1'b0;
            busy     <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
